// File: rtl/vga_pixel_fetch_pkg.sv
// Shared types and constants for the VGA pixel prefetcher.
package asip_pkg;

  typedef logic [31:0]  lane_t;
  typedef logic [191:0] word_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned LANES_PER_PIX  = 3;
  localparam int unsigned LANES_PER_WORD = 6;

  typedef enum logic [1:0] {
    StRewind,
    StFill,
    StRun
  } fetch_state_e;

  // Each component is the low byte of its lane; half selects the second pixel of the word.
  function automatic rgb_t unpack_pixel(input word_t word, input logic half);
    rgb_t px;
    if (half) begin
      px.r = word[(LANES_PER_PIX + 0) * 32 +: 8];
      px.g = word[(LANES_PER_PIX + 1) * 32 +: 8];
      px.b = word[(LANES_PER_PIX + 2) * 32 +: 8];
    end else begin
      px.r = word[0 * 32 +: 8];
      px.g = word[1 * 32 +: 8];
      px.b = word[2 * 32 +: 8];
    end
    return px;
  endfunction

endpackage

// File: rtl/vga_pixel_fetch_if.sv
// Image RAM read port: strobe plus lane address out, word returned one clk later.
interface vga_pixel_fetch_if #(
  parameter int unsigned V = 192,
  parameter int unsigned S = 32
) ();

  logic [S-1:0] mem_addr;
  logic         mem_re;
  logic [V-1:0] mem_rd;

  modport master (
    output mem_addr,
    output mem_re,
    input  mem_rd
  );

  modport slave (
    input  mem_addr,
    input  mem_re,
    output mem_rd
  );

endinterface

// File: rtl/vga_pixel_fetch_fifo.sv
// Small synchronous word FIFO holding prefetched image words; head word is shown combinationally.
module pixel_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 192,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = store[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Word storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Prefetching pixel streamer: raster-order 192-bit reads into a word FIFO, two RGB pixels per word,
// registered r/g/b aligned to the pixel tick.
// Optional build macro VGA_PIXFETCH_STATS_EN adds underflow_cnt and frame_cnt outputs.
module vga_pixel_fetch
  import asip_pkg::*;
#(
  parameter int unsigned V         = 192,
  parameter int unsigned S         = 32,
  parameter int unsigned IMG_W     = 100,
  parameter int unsigned IMG_H     = 100,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_tick,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               video_on,
  vga_pixel_fetch_if.master  mem,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic               underflow
`ifdef VGA_PIXFETCH_STATS_EN
  ,
  output logic [15:0]        underflow_cnt,
  output logic [15:0]        frame_cnt
`endif
);

  localparam int unsigned TotalWords = IMG_W * IMG_H / 2;
  localparam int unsigned IW         = $clog2(TotalWords + 1);
  localparam int unsigned CW         = $clog2(DEPTH + 1);
  localparam logic [9:0]  ImgW10     = 10'(IMG_W);
  localparam logic [9:0]  ImgH10     = 10'(IMG_H);

  fetch_state_e  state_q;
  logic [S-1:0]  rd_ptr_q;
  logic [S-1:0]  mem_addr_q;
  logic [IW-1:0] issued_q;
  logic          mem_re_q;
  logic          cap_q;

  logic          half_q;
  logic          underflow_q;
  rgb_t          rgb_q;

  logic [V-1:0]  fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic          fifo_pop;
  logic          fifo_flush;
  logic [CW:0]   occ;

  logic          window;
  logic          uf_ev;
  logic          rewind_trig;
  logic          issue;
  rgb_t          px;

  assign window      = pix_tick & video_on & (x < ImgW10) & (y < ImgH10);
  assign rewind_trig = pix_tick & (x == 10'd0) & (y == ImgH10);
  assign uf_ev       = window & fifo_empty & ~half_q;
  assign fifo_pop    = window & half_q & ~fifo_empty;
  assign fifo_flush  = (state_q == StRewind);
  assign px          = unpack_pixel(fifo_rdata, half_q);

  // Words already buffered plus the one whose data lands this cycle.
  assign occ   = {1'b0, fifo_cnt} + {{CW{1'b0}}, cap_q};
  assign issue = ((state_q == StFill) || (state_q == StRun)) && !mem_re_q && !rewind_trig &&
                 (occ < (CW + 1)'(DEPTH)) && (issued_q < IW'(TotalWords));

  pixel_word_fifo #(
    .DEPTH(DEPTH),
    .W    (V)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cap_q),
    .pop  (fifo_pop),
    .flush(fifo_flush),
    .wdata(mem.mem_rd),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );

  // Fetch FSM: rewind at vertical blanking, fill ahead of the beam, then keep the FIFO topped up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRewind;
      rd_ptr_q   <= S'(BASE_ADDR);
      mem_addr_q <= S'(BASE_ADDR);
      issued_q   <= '0;
      mem_re_q   <= 1'b0;
      cap_q      <= 1'b0;
    end else begin
      // Read data is valid the cycle after the strobe and is pushed at the end of it.
      cap_q    <= mem_re_q;
      mem_re_q <= 1'b0;
      if (issue) begin
        mem_re_q   <= 1'b1;
        mem_addr_q <= rd_ptr_q;
        rd_ptr_q   <= rd_ptr_q + S'(LANES_PER_WORD);
        issued_q   <= issued_q + 1'b1;
      end
      unique case (state_q)
        StRewind: begin
          rd_ptr_q <= S'(BASE_ADDR);
          issued_q <= '0;
          cap_q    <= 1'b0;
          state_q  <= StFill;
        end
        StFill: begin
          if (rewind_trig) begin
            state_q <= StRewind;
          end else if (fifo_full || (issued_q == IW'(TotalWords))) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (rewind_trig) state_q <= StRewind;
        end
        default: state_q <= StRewind;
      endcase
    end
  end

  // Pixel consume: register r/g/b on the tick, track half-word position and sticky underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q       <= '0;
      half_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (pix_tick) begin
        rgb_q <= (window && !uf_ev) ? px : '0;
      end
      if (state_q == StRewind) begin
        half_q      <= 1'b0;
        underflow_q <= 1'b0;
      end else if (window) begin
        if (uf_ev) begin
          underflow_q <= 1'b1;
        end else begin
          half_q <= ~half_q;
        end
      end
    end
  end

`ifdef VGA_PIXFETCH_STATS_EN
  logic [15:0] uf_cnt_q;
  logic [15:0] frame_cnt_q;

  // Statistics: saturating underflow events, wrapping frame count; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uf_cnt_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (uf_ev && (state_q != StRewind) && (uf_cnt_q != 16'hFFFF)) begin
        uf_cnt_q <= uf_cnt_q + 16'd1;
      end
      if (state_q == StRewind) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign underflow_cnt = uf_cnt_q;
  assign frame_cnt     = frame_cnt_q;
`endif

  assign mem.mem_re   = mem_re_q;
  assign mem.mem_addr = mem_addr_q;
  assign r            = rgb_q.r;
  assign g            = rgb_q.g;
  assign b            = rgb_q.b;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Scoreboard bench for vga_pixel_fetch: stimulus queues expected pixels, monitors compare.
module tb_vga_pixel_fetch;
  import asip_pkg::*;

  localparam int unsigned IMG_W = 100;
  localparam int unsigned IMG_H = 100;
  localparam int unsigned BASE  = 0;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       underflow;
`ifdef VGA_PIXFETCH_STATS_EN
  logic [15:0] underflow_cnt;
  logic [15:0] frame_cnt;
`endif

  vga_pixel_fetch_if #(.V(192), .S(32)) mem ();

  vga_pixel_fetch #(
    .V        (192),
    .S        (32),
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .BASE_ADDR(BASE),
    .DEPTH    (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pix_tick (pix_tick),
    .x        (x),
    .y        (y),
    .video_on (video_on),
    .mem      (mem.master),
    .r        (r),
    .g        (g),
    .b        (b),
    .underflow(underflow)
`ifdef VGA_PIXFETCH_STATS_EN
    ,
    .underflow_cnt(underflow_cnt),
    .frame_cnt    (frame_cnt)
`endif
  );

  always #10 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  rgb_t exp_q[$];
  int   rd_cnt    = 0;
  int   last_addr = -1;
  int   pix_n     = 0;

  // Lane k of word w reads back as 0x10*w + k.
  function automatic word_t model_word(input logic [31:0] addr);
    word_t       wd;
    int unsigned w;
    wd = '0;
    w  = (addr - BASE) / 6;
    for (int k = 5; k >= 0; k--) begin
      wd = {wd[159:0], 32'(16 * w + k)};
    end
    return wd;
  endfunction

  function automatic rgb_t exp_pix(input int p);
    rgb_t        e;
    int unsigned w;
    int unsigned k0;
    w   = p / 2;
    k0  = (p % 2) * 3;
    e.r = 8'(16 * w + k0);
    e.g = 8'(16 * w + k0 + 1);
    e.b = 8'(16 * w + k0 + 2);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Memory read port model: one clk latency.
  always @(posedge clk) begin
    if (mem.mem_re) mem.mem_rd <= model_word(mem.mem_addr);
  end

  // Read monitor: reads since the last rewind/reset must walk the image in word steps.
  initial begin
    forever begin
      @(negedge clk);
      if (mem.mem_re === 1'b1) begin
        check("rd_addr", 64'(mem.mem_addr), 64'(BASE + 6 * rd_cnt));
        last_addr = int'(mem.mem_addr);
        rd_cnt++;
      end
    end
  end

  // Pixel monitor: every sampled tick produces one registered r/g/b value.
  initial begin : pix_mon
    logic t;
    rgb_t e;
    forever begin
      @(posedge clk);
      t = pix_tick;
      #1;
      if (t === 1'b1 && rst === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rgb_unexpected actual=%02h%02h%02h required=none", r, g, b);
        end else begin
          e = exp_q.pop_front();
          check("rgb", 64'({r, g, b}), 64'(e));
        end
      end
    end
  end

  // Called at a negedge; one tick per two clk, like the 25 MHz pixel clock.
  task automatic tick(input int tx, input int ty, input logic von, input logic exp_uf);
    logic win;
    rgb_t e;
    x        = 10'(tx);
    y        = 10'(ty);
    video_on = von;
    pix_tick = 1'b1;
    win      = von && (tx < int'(IMG_W)) && (ty < int'(IMG_H));
    if (!win || exp_uf) begin
      e = '0;
    end else begin
      e = exp_pix(pix_n);
      pix_n++;
    end
    exp_q.push_back(e);
    @(negedge clk);
    pix_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame();
    for (int ty = 0; ty < 102; ty++) begin
      for (int tx = 0; tx < 110; tx++) begin
        if (tx == 0 && ty == int'(IMG_H)) begin
          check("frame_reads", 64'(rd_cnt), 64'(IMG_W * IMG_H / 2));
          check("last_addr", 64'(last_addr), 64'(BASE + 29994));
          check("frame_underflow", 64'(underflow), 64'(0));
          rd_cnt = 0;
          pix_n  = 0;
        end
        tick(tx, ty, (tx < 105) && (ty < 101), 1'b0);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    pix_tick = 1'b0;
    x        = '0;
    y        = '0;
    video_on = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rgb", 64'({r, g, b}), 64'(0));
    check("rst_mem_re", 64'(mem.mem_re), 64'(0));
    check("rst_underflow", 64'(underflow), 64'(0));
    check("rst_mem_addr", 64'(mem.mem_addr), 64'(BASE));
    rst = 1'b0;
    @(posedge clk);
    #1 check("first_re_early", 64'(mem.mem_re), 64'(0));
    @(posedge clk);
    #1 check("first_re", 64'(mem.mem_re), 64'(1));
    repeat (30) @(negedge clk);
    check("fill_reads", 64'(rd_cnt), 64'(DEPTH));
    check("fill_idle_re", 64'(mem.mem_re), 64'(0));

    run_frame();

    // Out-of-window tick with video_on: zero output and no pop.
    tick(150, 50, 1'b1, 1'b0);
    tick(0, 0, 1'b1, 1'b0);
    tick(1, 0, 1'b1, 1'b0);
    tick(2, 0, 1'b1, 1'b0);
    check("refill_reads", 64'(rd_cnt), 64'(DEPTH + 1));

    // Asynchronous reset mid-frame.
    rst = 1'b1;
    #1;
    check("async_rst_rgb", 64'({r, g, b}), 64'(0));
    check("async_rst_re", 64'(mem.mem_re), 64'(0));
    rd_cnt = 0;
    pix_n  = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // FIFO is empty right after reset: the consume underflows.
    tick(0, 0, 1'b1, 1'b1);
    check("underflow_set", 64'(underflow), 64'(1));
`ifdef VGA_PIXFETCH_STATS_EN
    check("underflow_cnt", 64'(underflow_cnt), 64'(1));
`endif
    repeat (10) @(negedge clk);
    check("underflow_sticky", 64'(underflow), 64'(1));
    rd_cnt = 0;
    tick(0, int'(IMG_H), 1'b0, 1'b0);
    check("underflow_clear", 64'(underflow), 64'(0));
    repeat (20) @(negedge clk);
    check("rewind_reads", 64'(rd_cnt), 64'(DEPTH));
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
